display_mux: RTL and testbench
==============================

DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit stays lit during scan.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces Reset-section values immediately.
REQ-004 status  input  2  calculator status: 00 error, 01 busy/streaming, 10 ready.
REQ-005 data  input  4  BCD digit for index pos; values 10-15 are non-numeric.
REQ-006 pos  input  4  digit index, 0 = least significant; valid 0-7.
REQ-007 an  output  8  digit anodes, active-low, one-hot-low while scanning.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 frame_done  output  1  one-cycle pulse when a new frame is committed to the display.

Function
REQ-010 States: IDLE, CAPTURE, SHOW, ERROR; encoded in 2 bits.
REQ-011 IDLE -> CAPTURE when status==01 and pos==0; SHOW -> CAPTURE under the same condition.
REQ-012 In CAPTURE, each cycle with status==01 and pos<=7 writes data into shadow[pos]; pos>=8 writes nothing.
REQ-013 CAPTURE -> SHOW on the first cycle status==10; same edge copies all 8 shadow digits to live registers and pulses frame_done for exactly one cycle.
REQ-014 Shadow digits not written during a frame keep their previous value.
REQ-015 status==00 in any state -> ERROR next edge; ERROR is exited only by reset; no commit, no frame_done.
REQ-016 In ERROR, live display shows "Erro" on digits 3..0 (E, r, r, o) and digits 7..4 blank; shadow writes ignored.
REQ-017 Refresh counter counts 0..REFRESH_DIV-1, wraps; on wrap scan index increments 0..7, 7 wraps to 0.
REQ-018 an[i]=0 only for i == scan index; all other bits 1; scanning runs in every state after reset.
REQ-019 Decode: 0-9 standard seven-segment; 10-15 display '-' (segment g only); blank = all segments off.
REQ-020 In IDLE, before any commit, all digits show 0 (or blank per REQ-026).
REQ-021 an and seg are registered; both change on the same edge, one cycle after scan index changes; no glitching between digits.
REQ-022 Commit and scan wrap on the same edge: scanned digit shows the new committed value from that edge onward.

Reset
REQ-023 On reset: state IDLE, an=8'hFF, seg=7'h7F, frame_done=0, refresh counter 0, scan index 0, shadow and live digits 0.
REQ-024 Reset asserted mid-CAPTURE discards the partial frame; live digits revert to 0.
REQ-025 First anode activation after reset release occurs REFRESH_DIV+1 cycles later at an=8'hFE.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: at commit, zero digits above the most significant non-zero digit are blanked; digit 0 always shown; all-zero value shows single "0".
REQ-027 Macro undefined: all 8 digits shown, leading zeros included; no blanking logic synthesized.
REQ-028 Macro has no effect on ERROR pattern.

Verification (REFRESH_DIV=4 on bench)
REQ-029 Reset held, then released -> an=8'hFF, seg=7'h7F until first wrap; then an=FE, FD, FB ... 7F, FE every 4 cycles.
REQ-030 status=01, pos 0..7 with data 3,2,1,0,0,0,0,0, then status=10 -> frame_done one pulse; digit0 seg=0110000 (3), digit2 seg=1111001 (1); digits 3-7 show 0 (macro off) or blank (macro on).
REQ-031 Stream with data=4'hC at pos 1 -> digit1 seg=0111111 ('-'), others per data.
REQ-032 status=00 mid-stream -> ERROR; digits 3..0 show E,r,r,o, digits 7..4 blank; frame_done stays 0; status=10 afterwards changes nothing until reset.
REQ-033 Reset asserted during CAPTURE after 4 digits -> all outputs at reset values immediately; new full frame after release displays correctly.
REQ-034 Second frame writing only pos 0..3 -> digits 4..7 retain first-frame values after commit.

Source files
------------

// File: rtl/display_mux.sv
// Eight-digit multiplexed seven-segment driver with a shadow/live frame buffer and calculator status FSM.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits at commit time.
module display_mux #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t        state, state_d;
  logic          commit, wr_en, wrap;
  logic [CW-1:0] refresh_cnt;
  logic [2:0]    scan_idx;
  logic          scan_en;
  logic [3:0]    shadow [8];
  logic [3:0]    live   [8];
  logic [3:0]    live_d [8];
  logic [3:0]    cur;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    wr_en   = 1'b0;
    if (status == 2'b00) begin
      state_d = ERROR;
    end else begin
      case (state)
        IDLE, SHOW: begin
          // The entering cycle already carries digit 0, so it is written too.
          if (status == 2'b01 && pos == 4'd0) begin
            state_d = CAPTURE;
            wr_en   = 1'b1;
          end
        end
        CAPTURE: begin
          if (status == 2'b01) begin
            wr_en = 1'b1;
          end else if (status == 2'b10) begin
            state_d = SHOW;
            commit  = 1'b1;
          end
        end
        default: state_d = ERROR;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  assign wrap = (refresh_cnt == CW'(REFRESH_DIV - 1));

  // The first wrap only enables scanning so the first lit digit is digit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      scan_en     <= 1'b0;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      if (wrap) begin
        if (!scan_en) scan_en  <= 1'b1;
        else          scan_idx <= scan_idx + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) live_d[i] = commit ? shadow[i] : live[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      if (wr_en && !pos[3]) shadow[pos[2:0]] <= data;
      for (int unsigned i = 0; i < 8; i++) live[i] <= live_d[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank, blank_d, lz;
  logic       seen;

  always_comb begin
    seen  = 1'b0;
    lz    = '0;
    for (int unsigned i = 7; i > 0; i--) begin
      if (shadow[i] != 4'd0) seen = 1'b1;
      lz[i] = !seen;
    end
    blank_d = commit ? lz : blank;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) blank <= 8'hFE;
    else       blank <= blank_d;
  end
`endif

  // Use next-cycle state and digits so a commit or error shows from its own edge.
  always_comb begin
    cur   = live_d[scan_idx];
    an_d  = scan_en ? ~(8'b1 << scan_idx) : '1;
    seg_d = '1;
    if (scan_en) begin
      if (state_d == ERROR) begin
        case (scan_idx)
          3'd0:    seg_d = 7'b0100011;
          3'd1:    seg_d = 7'b0101111;
          3'd2:    seg_d = 7'b0101111;
          3'd3:    seg_d = 7'b0000110;
          default: seg_d = '1;
        endcase
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = blank_d[scan_idx] ? '1 : decode(cur);
`else
        seg_d = decode(cur);
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an         <= '1;
      seg        <= '1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Randomized scoreboard bench for display_mux: committed frames are queued by the stimulus model
// and retired by a monitor on frame_done, which also checks every scanned anode/segment pair.
module tb_display_mux;
  localparam int unsigned DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = '0;
  logic [3:0] pos = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_done;

  always #5 clock = ~clock;

  display_mux #(.REFRESH_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  typedef struct packed {
    int unsigned due;
    logic [31:0] digs;
    logic [7:0]  blank;
  } frame_t;

  frame_t      sbq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned k = 0;
  logic [31:0] m_shadow;
  logic [31:0] exp_digs;
  logic [7:0]  exp_blank;
  bit          m_err;
  int          m_mode;  // 0 idle, 1 capturing, 2 showing, 3 error

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] err_glyph(input int idx);
    case (idx)
      0: return 7'b0100011;
      1: return 7'b0101111;
      2: return 7'b0101111;
      3: return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7:0] lz_mask(input logic [31:0] d);
    logic [7:0] m = '0;
`ifdef LEADING_ZERO_BLANK_EN
    bit seen = 0;
    for (int i = 7; i >= 1; i--) begin
      if (d[i*4 +: 4] != 4'd0) seen = 1;
      m[i] = !seen;
    end
`endif
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d t=%0t", name, act, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_err     = 0;
    m_shadow  = '0;
    exp_digs  = '0;
    exp_blank = lz_mask('0);
    sbq.delete();
    k = 0;
  endtask

  always @(posedge clock) begin
    if (reset) k = 0;
    else       k++;
  end

  // Monitor: retire frames on frame_done and check every displayed digit.
  always @(negedge clock) begin
    logic [7:0] ean;
    logic [6:0] eseg;
    logic       efd;
    int         idx;
    efd = (sbq.size() > 0) && (sbq[0].due <= k);
    check("frame_done", frame_done, efd);
    if ((frame_done || efd) && sbq.size() > 0) begin
      frame_t f;
      f = sbq.pop_front();
      exp_digs  = f.digs;
      exp_blank = f.blank;
    end
    if (reset || k < DIV + 1) begin
      ean  = 8'hFF;
      eseg = 7'h7F;
    end else begin
      idx  = int'(((k - DIV - 1) / DIV) % 8);
      ean  = ~(8'b1 << idx);
      if (m_err)               eseg = err_glyph(idx);
      else if (exp_blank[idx]) eseg = 7'h7F;
      else                     eseg = glyph(exp_digs[idx*4 +: 4]);
    end
    check("an", an, ean);
    check("seg", seg, eseg);
  end

  task automatic model_step(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    if (m_mode == 3) return;
    if (st == 2'b00) begin
      m_mode = 3;
      m_err  = 1;
      return;
    end
    if (m_mode == 1) begin
      if (st == 2'b01 && p < 4'd8) m_shadow[p[2:0]*4 +: 4] = d;
      else if (st == 2'b10) begin
        sbq.push_back('{due: k + 1, digs: m_shadow, blank: lz_mask(m_shadow)});
        m_mode = 2;
      end
    end else if (st == 2'b01 && p == 4'd0) begin
      m_mode = 1;
      m_shadow[3:0] = d;
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    @(negedge clock);
    #1;
    status = st;
    pos    = p;
    data   = d;
    model_step(st, p, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b10, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic frame(input logic [31:0] digs, input logic [7:0] mask);
    drive(2'b01, 4'd0, digs[3:0]);
    for (int i = 1; i < 8; i++)
      if (mask[i]) drive(2'b01, 4'(i), digs[i*4 +: 4]);
    drive(2'b10, 4'd0, 4'd0);
    idle(36);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset  = 1'b1;
    status = 2'b10;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_frame_done", frame_done, 1'b0);
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic random_frame();
    logic [3:0] d;
    drive(2'b01, 4'd0, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
    repeat ($urandom_range(1, 12)) begin
      d = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 7) == 0) drive(2'b11, 4'($urandom_range(0, 15)), d);
      else                           drive(2'b01, 4'($urandom_range(0, 15)), d);
    end
    drive(2'b10, 4'd0, 4'd0);
    idle($urandom_range(2, 40));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
    idle(40);
    frame(32'h0000_0123, 8'hFF);
    frame(32'h0000_00C5, 8'hFF);
    frame(32'h8765_4321, 8'hFF);
    frame(32'h0000_0906, 8'h0F);
    drive(2'b01, 4'd0, 4'd1);
    drive(2'b01, 4'd9, 4'd7);
    drive(2'b01, 4'd15, 4'd2);
    drive(2'b10, 4'd0, 4'd0);
    idle(36);
    for (int n = 0; n < 20; n++) random_frame();
    idle(36);
    drive(2'b01, 4'd0, 4'd5);
    drive(2'b01, 4'd1, 4'd6);
    drive(2'b01, 4'd2, 4'd7);
    drive(2'b01, 4'd3, 4'd8);
    do_reset();
    idle(8);
    frame(32'h1020_3004, 8'hFF);
    drive(2'b01, 4'd0, 4'd9);
    drive(2'b01, 4'd1, 4'd9);
    drive(2'b00, 4'd2, 4'd9);
    for (int i = 0; i < 40; i++)
      drive(2'($urandom_range(1, 2)), (i % 5 == 0) ? 4'd0 : 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    do_reset();
    idle(6);
    frame(32'h0004_0302, 8'hFF);
    idle(4);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
